// File: rtl/vga_capture.sv
// vga_capture: samples a pixel-strobed VGA stream and emits framebuffer writes.
// Ports:
//   clk, reset        - sole clock, asynchronous active-high reset
//   pix_en            - one-clk pixel strobe; VGA inputs valid only when high
//   enable            - capture permitted (acted on only when leaving/entering IDLE)
//   vga_color/hsync/vsync/blank_n - incoming VGA stream
//   sig_write/pixel/color - framebuffer write strobe, address, data
//   frame_done        - one-clk pulse per completed frame
//   line_err/frame_err - sticky geometry errors
//   busy              - high while ARMED or CAPTURE
module vga_capture #(
    parameter int   H_ACTIVE     = 800,
    parameter int   V_ACTIVE     = 600,
    parameter logic HSYNC_ACTIVE = 1'b0,
    parameter logic VSYNC_ACTIVE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        enable,
    input  logic [23:0] vga_color,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic        vga_blank_n,
    output logic        sig_write,
    output logic [19:0] pixel,
    output logic [23:0] color,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err,
    output logic        busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    localparam logic [19:0] L_TOTAL = 20'(H_ACTIVE * V_ACTIVE);
    localparam logic [10:0] L_H     = 11'(H_ACTIVE);
    localparam logic [10:0] L_V     = 11'(V_ACTIVE);

    logic [1:0]  r_state;
    logic [10:0] r_x;
    logic [10:0] r_y;
    logic [19:0] r_addr;
    logic        r_vs_d;
    logic        r_hs_d;
    logic        r_bn_d;
    logic        r_write;
    logic [19:0] r_pixel;
    logic [23:0] r_color;
    logic        r_fdone;
    logic        r_lerr;
    logic        r_ferr;

    logic w_vs_on;
    logic w_vs_rise;
    logic w_hs_rise;
    logic w_bn_fall;
    logic w_unused_hs;

    // Edges compare the current sample with the previous *sampled* value,
    // so history only advances on pix_en.
    assign w_vs_on   = (vga_vsync == VSYNC_ACTIVE);
    assign w_vs_rise = w_vs_on && (r_vs_d != VSYNC_ACTIVE);
    assign w_hs_rise = (vga_hsync == HSYNC_ACTIVE) && (r_hs_d != HSYNC_ACTIVE);
    assign w_bn_fall = r_bn_d && !vga_blank_n;

    // hsync edge is tracked for history only; addressing ignores it.
    assign w_unused_hs = w_hs_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_addr  <= '0;
            r_vs_d  <= 1'b0;
            r_hs_d  <= 1'b0;
            r_bn_d  <= 1'b0;
            r_write <= 1'b0;
            r_pixel <= '0;
            r_color <= '0;
            r_fdone <= 1'b0;
            r_lerr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_write <= 1'b0;
            r_fdone <= 1'b0;
            if (pix_en) begin
                r_vs_d <= vga_vsync;
                r_hs_d <= vga_hsync;
                r_bn_d <= vga_blank_n;
                case (r_state)
                    S_IDLE: begin
                        if (w_vs_rise && enable) begin
                            r_state <= S_ARMED;
                            r_lerr  <= 1'b0;
                            r_ferr  <= 1'b0;
                        end
                    end
                    S_ARMED: begin
                        if (!w_vs_on) begin
                            r_state <= S_CAPTURE;
                            r_x     <= '0;
                            r_y     <= '0;
                            r_addr  <= '0;
                        end
                    end
                    S_CAPTURE: begin
                        if (w_vs_rise) begin
                            // Frame boundary takes priority over active video.
                            r_fdone <= 1'b1;
                            if (r_y != L_V) begin
                                r_ferr <= 1'b1;
                            end
                            r_state <= enable ? S_ARMED : S_IDLE;
                        end else if (!w_vs_on) begin
                            if (vga_blank_n) begin
                                // x tracks line length even after the
                                // address has run out.
                                if (r_x != '1) begin
                                    r_x <= r_x + 11'd1;
                                end
                                if (r_addr < L_TOTAL) begin
                                    r_write <= 1'b1;
                                    r_pixel <= r_addr;
                                    r_color <= vga_color;
                                    r_addr  <= r_addr + 20'd1;
                                end else begin
                                    r_ferr <= 1'b1;
                                end
                            end else if (w_bn_fall) begin
                                if (r_x != L_H) begin
                                    r_lerr <= 1'b1;
                                end
                                if (r_y != '1) begin
                                    r_y <= r_y + 11'd1;
                                end
                                r_x <= '0;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign sig_write  = r_write;
    assign pixel      = r_pixel;
    assign color      = r_color;
    assign frame_done = r_fdone;
    assign line_err   = r_lerr;
    assign frame_err  = r_ferr;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: directed vectors and frame sequences for vga_capture.
// Runs a scaled-down geometry so full frames fit in a short simulation.
module tb_vga_capture;

    localparam int   H      = 8;
    localparam int   V      = 6;
    localparam int   TOTAL  = H * V;
    localparam logic HS_ON  = 1'b0;
    localparam logic HS_OFF = 1'b1;
    localparam logic VS_ON  = 1'b1;
    localparam logic VS_OFF = 1'b0;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic        enable;
    logic [23:0] vga_color;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_blank_n;
    logic        sig_write;
    logic [19:0] pixel;
    logic [23:0] color;
    logic        frame_done;
    logic        line_err;
    logic        frame_err;
    logic        busy;

    always #5 clk = ~clk;

    vga_capture #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .HSYNC_ACTIVE(HS_ON),
        .VSYNC_ACTIVE(VS_ON)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pix_en(pix_en),
        .enable(enable),
        .vga_color(vga_color),
        .vga_hsync(vga_hsync),
        .vga_vsync(vga_vsync),
        .vga_blank_n(vga_blank_n),
        .sig_write(sig_write),
        .pixel(pixel),
        .color(color),
        .frame_done(frame_done),
        .line_err(line_err),
        .frame_err(frame_err),
        .busy(busy)
    );

    typedef struct {
        logic        pe;
        logic        en;
        logic        vs;
        logic        bn;
        logic [23:0] c;
        logic        sw;
        logic [19:0] pix;
        logic [23:0] col;
        logic        bsy;
        logic        fd;
        logic        ferr;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    int n_wr = 0;
    int n_fd = 0;
    int exp_addr = 0;
    int col = 0;
    int div = 1;
    bit mon_on = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, let the edge pass, look at outputs 1ns later.
    task automatic step(input logic pe, input logic [23:0] c,
                        input logic hs, input logic vs, input logic bn);
        pix_en      = pe;
        vga_color   = c;
        vga_hsync   = hs;
        vga_vsync   = vs;
        vga_blank_n = bn;
        @(posedge clk);
        #1;
        if (mon_on) begin
            if (sig_write) begin
                chk("write_after_strobe", {31'd0, pe}, 32'd1);
                chk("pixel_seq", {12'd0, pixel}, 32'(exp_addr));
                chk("color_seq", {8'd0, color}, 32'(exp_addr));
                exp_addr++;
                n_wr++;
            end
            if (frame_done) n_fd++;
        end
    endtask

    // One VGA sample: a strobed clock followed by div-1 idle clocks.
    task automatic samp(input logic [23:0] c, input logic hs,
                        input logic vs, input logic bn);
        step(1'b1, c, hs, vs, bn);
        for (int i = 1; i < div; i++) step(1'b0, c, hs, vs, bn);
    endtask

    task automatic vsync_pulse();
        repeat (2) samp(24'd0, HS_OFF, VS_ON, 1'b0);
        repeat (2) samp(24'd0, HS_OFF, VS_OFF, 1'b0);
    endtask

    // Drives nl lines; colour of each active pixel is its frame address.
    // Line short_l is one pixel short; stop_at aborts after that many pixels.
    task automatic lines(input int nl, input int short_l, input int stop_at);
        col = 0;
        for (int l = 0; l < nl; l++) begin
            int len;
            len = (l == short_l) ? H - 1 : H;
            for (int p = 0; p < len; p++) begin
                if (col == stop_at) return;
                samp(24'(col), HS_OFF, VS_OFF, 1'b1);
                col++;
            end
            samp(24'd0, HS_OFF, VS_OFF, 1'b0);
            if (l < V)
                chk("line_err", {31'd0, line_err},
                    (short_l >= 0 && l >= short_l) ? 32'd1 : 32'd0);
            samp(24'd0, HS_ON, VS_OFF, 1'b0);
            samp(24'd0, HS_OFF, VS_OFF, 1'b0);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        chk("rst_sig_write", {31'd0, sig_write}, 32'd0);
        chk("rst_pixel", {12'd0, pixel}, 32'd0);
        chk("rst_color", {8'd0, color}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_line_err", {31'd0, line_err}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        step(1'b0, 24'd0, HS_OFF, VS_OFF, 1'b0);
        reset = 1'b0;
        n_wr = 0;
        n_fd = 0;
        exp_addr = 0;
    endtask

    task automatic full_frame_checks(input string tag);
        vsync_pulse();
        lines(V, -1, -1);
        vsync_pulse();
        chk({tag, "_writes"}, 32'(n_wr), 32'(TOTAL));
        chk({tag, "_last_pixel"}, {12'd0, pixel}, 32'(TOTAL - 1));
        chk({tag, "_frame_done"}, 32'(n_fd), 32'd1);
        chk({tag, "_line_err"}, {31'd0, line_err}, 32'd0);
        chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    vec_t tv[13];

    initial begin
        reset = 1'b0;
        pix_en = 1'b0;
        enable = 1'b1;
        vga_color = '0;
        vga_hsync = HS_OFF;
        vga_vsync = VS_OFF;
        vga_blank_n = 1'b0;

        //          pe    en    vs    bn    c          sw    pix    col        bsy   fd    ferr
        tv[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 20'd0, 24'h000000, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 20'd0, 24'h000000, 1'b1, 1'b0, 1'b0};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 24'hAAAAAA, 1'b0, 20'd0, 24'h000000, 1'b1, 1'b0, 1'b0};
        tv[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 20'd0, 24'h000000, 1'b1, 1'b0, 1'b0};
        tv[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 24'h123456, 1'b1, 20'd0, 24'h123456, 1'b1, 1'b0, 1'b0};
        tv[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 24'hFFFFFF, 1'b0, 20'd0, 24'h123456, 1'b1, 1'b0, 1'b0};
        tv[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 24'h00ABCD, 1'b1, 20'd1, 24'h00ABCD, 1'b1, 1'b0, 1'b0};
        tv[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 24'h777777, 1'b0, 20'd1, 24'h00ABCD, 1'b1, 1'b1, 1'b1};
        tv[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 20'd1, 24'h00ABCD, 1'b1, 1'b0, 1'b1};
        tv[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 20'd1, 24'h00ABCD, 1'b1, 1'b0, 1'b1};
        tv[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0, 20'd1, 24'h00ABCD, 1'b0, 1'b1, 1'b1};
        tv[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 20'd1, 24'h00ABCD, 1'b0, 1'b0, 1'b1};
        tv[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 20'd1, 24'h00ABCD, 1'b1, 1'b0, 1'b0};

        #2;
        apply_reset();
        mon_on = 0;
        for (int i = 0; i < 13; i++) begin
            enable = tv[i].en;
            step(tv[i].pe, tv[i].c, HS_OFF, tv[i].vs, tv[i].bn);
            chk($sformatf("vec%0d_sig_write", i), {31'd0, sig_write}, {31'd0, tv[i].sw});
            chk($sformatf("vec%0d_pixel", i), {12'd0, pixel}, {12'd0, tv[i].pix});
            chk($sformatf("vec%0d_color", i), {8'd0, color}, {8'd0, tv[i].col});
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, tv[i].bsy});
            chk($sformatf("vec%0d_frame_done", i), {31'd0, frame_done}, {31'd0, tv[i].fd});
            chk($sformatf("vec%0d_frame_err", i), {31'd0, frame_err}, {31'd0, tv[i].ferr});
        end

        mon_on = 1;
        enable = 1'b1;

        // Full frame, strobe every clock.
        apply_reset();
        full_frame_checks("full");

        // Short line in the middle of the frame.
        apply_reset();
        vsync_pulse();
        lines(V, 2, -1);
        vsync_pulse();
        chk("short_writes", 32'(n_wr), 32'(TOTAL - 1));
        chk("short_last_pixel", {12'd0, pixel}, 32'(TOTAL - 2));
        chk("short_frame_done", 32'(n_fd), 32'd1);
        chk("short_line_err", {31'd0, line_err}, 32'd1);
        chk("short_frame_err", {31'd0, frame_err}, 32'd0);

        // One line too many: address saturates, no wrap.
        apply_reset();
        vsync_pulse();
        lines(V + 1, -1, -1);
        chk("over_writes", 32'(n_wr), 32'(TOTAL));
        chk("over_last_pixel", {12'd0, pixel}, 32'(TOTAL - 1));
        chk("over_frame_err", {31'd0, frame_err}, 32'd1);
        chk("over_no_done_yet", 32'(n_fd), 32'd0);
        vsync_pulse();
        chk("over_frame_done", 32'(n_fd), 32'd1);
        chk("over_frame_err_sticky", {31'd0, frame_err}, 32'd1);

        // Strobe every third clock.
        apply_reset();
        div = 3;
        full_frame_checks("div3");
        div = 1;

        // Reset in the middle of a frame.
        apply_reset();
        vsync_pulse();
        lines(V, -1, 2 * H + 3);
        chk("midrst_writes_before", 32'(n_wr), 32'(2 * H + 3));
        apply_reset();
        lines(V, -1, -1);
        chk("midrst_no_writes", 32'(n_wr), 32'd0);
        chk("midrst_idle", {31'd0, busy}, 32'd0);
        vsync_pulse();
        chk("midrst_no_done", 32'(n_fd), 32'd0);
        chk("midrst_armed", {31'd0, busy}, 32'd1);
        lines(V, -1, -1);
        vsync_pulse();
        chk("midrst_writes_after", 32'(n_wr), 32'(TOTAL));
        chk("midrst_done_after", 32'(n_fd), 32'd1);

        // Capture disabled at frame start, enabled mid-frame.
        apply_reset();
        enable = 1'b0;
        vsync_pulse();
        chk("dis_busy", {31'd0, busy}, 32'd0);
        lines(2, -1, -1);
        enable = 1'b1;
        lines(V - 2, -1, -1);
        chk("dis_no_writes", 32'(n_wr), 32'd0);
        chk("dis_still_idle", {31'd0, busy}, 32'd0);
        vsync_pulse();
        chk("dis_no_done", 32'(n_fd), 32'd0);
        chk("dis_armed", {31'd0, busy}, 32'd1);
        lines(V, -1, -1);
        vsync_pulse();
        chk("dis_writes_next", 32'(n_wr), 32'(TOTAL));
        chk("dis_done_next", 32'(n_fd), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameter H_ACTIVE, default 800, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 600, active lines per frame.
REQ-003 Parameter HSYNC_ACTIVE, default 0, hsync asserted level; VSYNC_ACTIVE, default 1, vsync asserted level.
REQ-004 Ports, clock and reset first:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high
- pix_en  in  1  one-clk pixel strobe; VGA inputs valid only when high
- enable  in  1  capture permitted
- vga_color  in  24  pixel colour
- vga_hsync  in  1  horizontal sync
- vga_vsync  in  1  vertical sync
- vga_blank_n  in  1  high = active video
- sig_write  out  1  framebuffer write strobe
- pixel  out  20  framebuffer write address
- color  out  24  framebuffer write data
- frame_done  out  1  one-clk pulse per completed frame
- line_err  out  1  sticky: line length != H_ACTIVE
- frame_err  out  1  sticky: line count != V_ACTIVE, or address overflow
- busy  out  1  high in ARMED or CAPTURE

Function
REQ-005 All VGA inputs are sampled only on clk edges with pix_en=1; with pix_en=0, counters, state, and edge history hold.
REQ-006 Sync edges are detected against the previous sampled value of the same signal: vsync assert, hsync assert, blank_n rise, blank_n fall.
REQ-007 States: IDLE, ARMED, CAPTURE.
REQ-008 IDLE -> ARMED on a vsync-assert sample while enable=1; enable=0 keeps IDLE; enable changes outside IDLE are ignored until the next IDLE.
REQ-009 ARMED -> CAPTURE on the first sample with vsync deasserted; x, y, and address clear to 0 on entry.
REQ-010 In CAPTURE, each sample with blank_n=1 and vsync deasserted gives, on the next clk: sig_write=1, pixel=address, color=sampled vga_color; address +1; x +1; latency exactly 1 clk.
REQ-011 sig_write is high for exactly one clk per captured pixel, otherwise 0; pixel and color hold their last values when sig_write=0.
REQ-012 Blank_n fall in CAPTURE: if x != H_ACTIVE, set line_err; y +1; x clears to 0.
REQ-013 Address reaching H_ACTIVE*V_ACTIVE: further active samples produce no write; frame_err set; address does not wrap.
REQ-014 Vsync assert in CAPTURE ends the frame: frame_done pulses 1 clk; frame_err set if y != V_ACTIVE; next state ARMED if enable=1, else IDLE.
REQ-015 Vsync assert coinciding with blank_n=1: vsync wins; no write for that sample.
REQ-016 Active video seen before the first blank_n fall after CAPTURE entry counts as a normal line.
REQ-017 hsync is monitored only for edge history; capture addressing is driven by blank_n and vsync.
REQ-018 line_err and frame_err clear only on reset or on IDLE -> ARMED.
REQ-019 x, y: 11-bit saturating counters; address: 20-bit.

Reset
REQ-020 Asynchronous reset forces IDLE; sig_write=0, pixel=0, color=0, frame_done=0, line_err=0, frame_err=0, busy=0; counters and edge history cleared.
REQ-021 Mid-frame reset discards the partial frame; no frame_done is produced for it; capture restarts only via REQ-008.

Verification
REQ-022 Bench SHALL cover these directed scenarios:
- Full 800x600 frame, pix_en every clk, colour = address -> 480000 writes, pixel 0..479999 in order, color matches, one frame_done, no errors.
- Line of 799 active pixels -> line_err=1 after that blank_n fall; following line starts at the correct sequential address.
- Frame of 601 lines -> writes stop at pixel 479999; frame_err=1; frame_done at vsync.
- pix_en high every 3rd clk -> identical write sequence; each sig_write 1 clk after its strobe.
- reset asserted at pixel 1000 -> all outputs zero immediately; no writes until next vsync with enable=1.
- enable=0 at frame start -> no writes, busy=0; enable=1 mid-frame -> capture begins at the following frame.
